// File: rtl/afu_stream_shell.sv
// Streaming shell: input line FIFO -> fixed-latency core -> output line FIFO, with credit-guarded issue and job length count.
// Issue one cycle after write; result visible two cycles after core_next_out. Define AFU_SHELL_STATS_EN for stall/idle counters.

module afu_stream_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  din,
  input  logic          we,
  input  logic          re,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count,
  output logic          rd_ok
);
  localparam int D = 1 << AW;

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          empty, full, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(D));
  assign rd_ok = re && !empty;
  // A write into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign wr_ok = we && (!full || rd_ok);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok)      count_d = count_q + (AW+1)'(1);
    else if (!wr_ok && rd_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end
endmodule

module afu_stream_shell #(
  parameter int DATA_WIDTH      = 32,
  parameter int LANES           = 16,
  parameter int BUFF_DEPTH_BITS = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [31:0]                         ctx_length,
  output logic                                busy,
  output logic                                done,
`ifdef AFU_SHELL_STATS_EN
  output logic [31:0]                         stall_cycles,
  output logic [31:0]                         idle_cycles,
`endif
  input  logic [LANES*DATA_WIDTH-1:0]         input_fifo_din,
  input  logic                                input_fifo_we,
  output logic                                input_fifo_full,
  output logic                                input_fifo_almost_full,
  output logic [BUFF_DEPTH_BITS:0]            input_fifo_count,
  output logic [LANES*DATA_WIDTH-1:0]         output_fifo_dout,
  input  logic                                output_fifo_re,
  output logic                                output_fifo_empty,
  output logic                                output_fifo_almost_empty,
  output logic [LANES*DATA_WIDTH-1:0]         core_in,
  output logic                                core_next,
  input  logic [LANES*DATA_WIDTH-1:0]         core_out,
  input  logic                                core_next_out
);
  localparam int LW = LANES * DATA_WIDTH;
  localparam int D  = 1 << BUFF_DEPTH_BITS;
  localparam int CW = BUFF_DEPTH_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     len_q, len_d, issued_q, issued_d, retired_q, retired_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [LW-1:0]   res_q, res_d;
  logic            res_vld_q, res_vld_d;
  logic [CW-1:0]   out_count;
  logic            in_empty, issue, in_pop, out_pop, start_acc;

  afu_stream_fifo #(.W(LW), .AW(BUFF_DEPTH_BITS)) u_in_fifo (
    .clk(clk), .reset(reset), .din(input_fifo_din), .we(input_fifo_we), .re(issue),
    .dout(core_in), .count(input_fifo_count), .rd_ok(in_pop)
  );

  afu_stream_fifo #(.W(LW), .AW(BUFF_DEPTH_BITS)) u_out_fifo (
    .clk(clk), .reset(reset), .din(res_q), .we(res_vld_q), .re(output_fifo_re),
    .dout(output_fifo_dout), .count(out_count), .rd_ok(out_pop)
  );

  assign in_empty                 = (input_fifo_count == '0);
  assign input_fifo_full          = (input_fifo_count == CW'(D));
  assign input_fifo_almost_full   = (input_fifo_count >= CW'(D - 4));
  assign output_fifo_empty        = (out_count == '0);
  assign output_fifo_almost_empty = (out_count <= CW'(2));

  assign issue     = (state_q == S_RUN) && !in_empty && (credits_q != '0) && (issued_q < len_q);
  assign core_next = in_pop;
  assign start_acc = start && (state_q != S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    issued_d  = issued_q + (in_pop ? 32'd1 : 32'd0);
    retired_d = retired_q + (res_vld_q ? 32'd1 : 32'd0);
    credits_d = credits_q;
    // Late results from a job killed by reset are ignored outside RUN.
    res_vld_d = core_next_out && (state_q == S_RUN);
    res_d     = res_vld_d ? core_out : res_q;
    if (in_pop && !out_pop)      credits_d = credits_q - CW'(1);
    else if (!in_pop && out_pop) credits_d = credits_q + CW'(1);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d   = (ctx_length != 32'd0) ? S_RUN : S_DONE;
          len_d     = ctx_length;
          issued_d  = '0;
          retired_d = '0;
        end
      end
      S_RUN: begin
        if (res_vld_q && (retired_q + 32'd1 == len_q)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      issued_q  <= '0;
      retired_q <= '0;
      credits_q <= CW'(D);
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      credits_q <= credits_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

`ifdef AFU_SHELL_STATS_EN
  logic [31:0] stall_q, stall_d, idle_q, idle_d;

  always_comb begin
    stall_d = stall_q;
    idle_d  = idle_q;
    if (start_acc) begin
      stall_d = '0;
      idle_d  = '0;
    end else if (state_q == S_RUN) begin
      if (in_empty) idle_d = idle_q + 32'd1;
      else if ((issued_q < len_q) && (credits_q == '0)) stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      idle_q  <= '0;
    end else begin
      stall_q <= stall_d;
      idle_q  <= idle_d;
    end
  end

  assign stall_cycles = stall_q;
  assign idle_cycles  = idle_q;
`endif
endmodule

// File: doc/afu_stream_shell.md
# afu_stream_shell

Parametrised streaming shell between the AFU line FIFOs and a fixed-latency compute core (FFT or similar). It buffers incoming cache lines, splits each into LANES words for the core and repacks core results into output lines. A credit counter guarantees the output FIFO can never overflow. A length counter runs a job of exactly ctx_length lines and reports completion.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one lane word
- LANES, 16, words per line; line width LW = LANES*DATA_WIDTH
- BUFF_DEPTH_BITS, 3, log2 depth D of each FIFO (D = 2^BUFF_DEPTH_BITS)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle job launch pulse
- ctx_length  in  32  job length in lines, sampled on start
- busy  out  1  high from accepted start until done
- done  out  1  high in DONE state until next start or reset
- input_fifo_din  in  LW  line to buffer
- input_fifo_we  in  1  write strobe
- input_fifo_full / input_fifo_almost_full  out  1  full / count >= D-4
- input_fifo_count  out  BUFF_DEPTH_BITS+1  entries held
- output_fifo_dout  out  LW  head line of output FIFO (show-ahead)
- output_fifo_re  in  1  pop strobe
- output_fifo_empty / output_fifo_almost_empty  out  1  empty / count <= 2
- core_in  out  LW  lane i = bits [DATA_WIDTH*i +: DATA_WIDTH]
- core_next  out  1  core input-valid pulse
- core_out  in  LW  core result, same lane packing
- core_next_out  in  1  core result-valid pulse

## Operation
- States IDLE, RUN, DONE. Reset enters IDLE.
- IDLE: start with ctx_length > 0 goes to RUN. start with ctx_length == 0 goes to DONE. Either transition clears issued_cnt and retired_cnt and latches len = ctx_length.
- RUN: issue = !input_empty && credits != 0 && issued_cnt < len.
  - core_next = issue. The input FIFO pops on issue.
  - core_in = input FIFO head (show-ahead).
  - issued_cnt increments on each issue.
- Core result capture: on core_next_out, core_out is registered. output_fifo_we is asserted on the next cycle and retired_cnt increments on that write.
- RUN goes to DONE when retired_cnt == len (evaluated on the write cycle). DONE goes to RUN or DONE on start, using the same rules as IDLE. start in RUN is ignored.
- Credits: BUFF_DEPTH_BITS+1 bits, reset value D.
  - Decrement on issue. Increment on an effective pop (output_fifo_re && !output_fifo_empty).
  - Both in the same cycle: no change.
  - credits + in-flight lines + output FIFO occupancy == D at all times.
- Input lines beyond len remain in the input FIFO for the next job. They are never issued.
- input_fifo_we while full: the line is dropped and the count is unchanged. output_fifo_re while empty: ignored, and no credit is returned.
- Reset mid-job: both FIFOs are flushed, all counters clear, credits return to D, and the state goes to IDLE. Core results arriving after reset are discarded until the next start.

## Timing
- Reset values: busy=0, done=0, core_next=0, input_fifo_full=0, input_fifo_almost_full=0, input_fifo_count=0, output_fifo_empty=1, output_fifo_almost_empty=1, output_fifo_dout=0, core_in=0.
- Input write to issue: the line written in cycle t can issue in cycle t+1.
- Core result to output: core_next_out in cycle t gives output_fifo_we in t+1 and the line visible at output_fifo_dout with empty=0 in t+2.
- Throughput is one line per cycle while credits are non-zero and input is available.
- done rises the cycle after the final output write.
- Simultaneous FIFO write and read at a full FIFO is legal. Count is unchanged.

## Configuration
- AFU_SHELL_STATS_EN defined: adds output ports stall_cycles[31:0] and idle_cycles[31:0], both cleared on an accepted start and on reset.
  - stall_cycles increments each RUN cycle with input non-empty, issued_cnt < len and credits == 0.
  - idle_cycles increments each RUN cycle with the input FIFO empty.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Basic job: D=8, core latency 5, ctx_length=4, 4 lines written, output_fifo_re held high. Required: 4 output lines equal to the per-lane core transform in order; done high 1 cycle after the 4th write; busy low from then on.
- Backpressure: ctx_length=20, output_fifo_re held low. Required: exactly 8 core_next pulses, then none. Then one pop per 3 cycles; each pop yields exactly one further issue. No overflow; 20 lines are eventually retired.
- Zero length: start with ctx_length=0. Required: done=1 next cycle; core_next never asserts; the input FIFO contents are untouched.
- Excess input: 6 lines written, ctx_length=4. Required: 4 issued and done. input_fifo_count=2. A second start with ctx_length=2 issues the remaining 2.
- Reset mid-job: assert reset after 3 of 10 issues. Required: all outputs reach their reset values asynchronously; the input FIFO count reads 0 after release; late core_next_out pulses produce no output write.
- Stats (AFU_SHELL_STATS_EN): repeat the backpressure case. Required: stall_cycles equals the number of cycles with credits == 0 and pending input; the counter clears to 0 on the next start.
